// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM state
// encoding and the requester count.
package rr_mux4_arbiter_pkg;

   localparam int N_REQ = 4;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;

endpackage : rr_mux4_arbiter_pkg

// File: rtl/rr_mux4_arbiter_ymux.sv
// Plain 4:1 word multiplexer; the arbiter steers the granted requester's
// word onto the shared output through this instance.
module yMux4to1 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in0_i,
   input  logic [WIDTH-1:0] in1_i,
   input  logic [WIDTH-1:0] in2_i,
   input  logic [WIDTH-1:0] in3_i,
   input  logic [1:0]       sel_i,
   output logic [WIDTH-1:0] out_o
);

   // Select one of the four input words.
   always_comb begin
      out_o = in0_i;
      case (sel_i)
         2'd0:    out_o = in0_i;
         2'd1:    out_o = in1_i;
         2'd2:    out_o = in2_i;
         default: out_o = in3_i;
      endcase
   end

endmodule : yMux4to1

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one sink between four valid/ready requesters.
// One word is forwarded per grant; every transfer is followed by one idle
// cycle in which the next requester is chosen, starting after the last one
// served.
module rr_mux4_arbiter
   import rr_mux4_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ready,
   output logic [1:0]         grant_id,
   output logic               busy
);

   state_e     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] ptr_q, ptr_d;
   logic       xfer;

   // First requesting index found when scanning ptr, ptr+1, ptr+2, ptr+3.
   function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] ptr);
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr + 2'(k);
         if (req[idx] && !found) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   yMux4to1 #(.WIDTH(WIDTH)) u_mux (
      .in0_i (in_data[0*WIDTH +: WIDTH]),
      .in1_i (in_data[1*WIDTH +: WIDTH]),
      .in2_i (in_data[2*WIDTH +: WIDTH]),
      .in3_i (in_data[3*WIDTH +: WIDTH]),
      .sel_i (sel_q),
      .out_o (out_data)
   );

   // Handshake outputs: the granted word is offered combinationally and
   // acknowledged only to the granted requester in the transfer cycle.
   always_comb begin
      out_valid = (state_q == S_GRANT) && in_valid[sel_q];
      xfer      = out_valid && out_ready;
      in_ready  = xfer ? (4'b0001 << sel_q) : 4'b0000;
   end

   // Next-state logic: pick in IDLE, hold or release in GRANT.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid != 4'b0000) begin
               sel_d   = rr_pick(in_valid, ptr_q);
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (xfer) begin
               ptr_d   = sel_q + 2'd1;
               state_d = S_IDLE;
            end else if (!in_valid[sel_q]) begin
               // Requester withdrew: give up the grant without advancing ptr.
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, select and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= 2'b00;
         ptr_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_id = sel_q;
   assign busy     = (state_q == S_GRANT);

endmodule : rr_mux4_arbiter

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: expected (requester, word) pairs are queued as
// stimulus is applied and popped by a monitor on every accepted transfer.
module tb_rr_mux4_arbiter;

   localparam int WIDTH = 32;

   typedef struct {
      logic [1:0]       id;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic [3:0]         in_valid;
   logic [4*WIDTH-1:0] in_data;
   logic [3:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic               out_ready;
   logic [1:0]         grant_id;
   logic               busy;

   logic [WIDTH-1:0] dat [4];
   exp_t             sb [$];
   int               checks;
   int               errors;
   int               pulses;
   int               p0;

   assign in_data = {dat[3], dat[2], dat[1], dat[0]};

   rr_mux4_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] id);
      exp_t e;
      e.id   = id;
      e.data = dat[id];
      sb.push_back(e);
   endtask

   // Monitor: every accepted word must match the head of the scoreboard;
   // in_ready must be zero whenever nothing is accepted.
   always @(negedge clk) begin
      exp_t e;
      if (in_ready != 4'b0000) pulses++;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_xfer", {30'd0, grant_id}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("xfer_gid", {30'd0, grant_id}, {30'd0, e.id});
            chk("xfer_data", out_data, e.data);
            chk("xfer_irdy", {28'd0, in_ready}, {28'd0, 4'b0001 << e.id});
         end
      end else begin
         chk("irdy_idle", {28'd0, in_ready}, 32'd0);
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      pulses    = 0;
      dat[0]    = 32'hA000_0000;
      dat[1]    = 32'hB111_1111;
      dat[2]    = 32'hC222_2222;
      dat[3]    = 32'hD333_3333;
      rst_n     = 1'b0;
      in_valid  = 4'hF;
      out_ready = 1'b0;

      // 1. reset with all requesting, then first grant goes to 0
      tick();
      tick();
      chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
      chk("rst_irdy", {28'd0, in_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_gid", {30'd0, grant_id}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_gid", {30'd0, grant_id}, 32'd0);
      chk("t1_ovalid", {31'd0, out_valid}, 32'd1);
      push(2'd0);
      out_ready = 1'b1;
      tick();
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      chk("t1_idle", {31'd0, busy}, 32'd0);

      // 2. single request from 2, then scan resumes at 3
      dat[2]    = 32'hDEAD_BEEF;
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      push(2'd2);
      tick();
      chk("t2_ovalid", {31'd0, out_valid}, 32'd1);
      chk("t2_odata", out_data, 32'hDEAD_BEEF);
      chk("t2_irdy", {28'd0, in_ready}, 32'h4);
      tick();
      chk("t2_irdy_after", {28'd0, in_ready}, 32'd0);
      chk("t2_busy_after", {31'd0, busy}, 32'd0);
      in_valid = 4'b1001;
      push(2'd3);
      tick();
      chk("t2_next_gid", {30'd0, grant_id}, 32'd3);
      tick();
      in_valid = 4'b0000;

      // 3. all requesting continuously: 0,1,2,3,0,1,2,3
      p0        = pulses;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++) push(2'(i));
      repeat (16) tick();
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      chk("t3_pulses", pulses - p0, 32'd8);
      chk("t3_sb_empty", sb.size(), 32'd0);

      // 4. backpressure on requester 1
      in_valid = 4'b0010;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_ovalid", {31'd0, out_valid}, 32'd1);
         chk("t4_gid", {30'd0, grant_id}, 32'd1);
         chk("t4_odata", out_data, dat[1]);
         chk("t4_irdy", {28'd0, in_ready}, 32'd0);
         tick();
      end
      push(2'd1);
      out_ready = 1'b1;
      tick();
      in_valid  = 4'b0000;
      out_ready = 1'b0;

      // 5. move ptr to 3, then requester 3 withdraws under backpressure
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      push(2'd2);
      tick();
      tick();
      in_valid  = 4'b1000;
      out_ready = 1'b0;
      tick();
      chk("t5_gid", {30'd0, grant_id}, 32'd3);
      chk("t5_ovalid", {31'd0, out_valid}, 32'd1);
      in_valid = 4'b0000;
      #2;
      chk("t5_wd_ovalid", {31'd0, out_valid}, 32'd0);
      chk("t5_wd_irdy", {28'd0, in_ready}, 32'd0);
      tick();
      chk("t5_wd_busy", {31'd0, busy}, 32'd0);
      in_valid  = 4'b1001;
      out_ready = 1'b1;
      push(2'd3);
      tick();
      chk("t5_regrant", {30'd0, grant_id}, 32'd3);
      tick();
      in_valid = 4'b0000;

      // 6. async reset mid-GRANT with ptr away from 0
      in_valid  = 4'b0010;
      out_ready = 1'b1;
      push(2'd1);
      tick();
      tick();
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      tick();
      chk("t6_busy", {31'd0, busy}, 32'd1);
      chk("t6_gid", {30'd0, grant_id}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ovalid", {31'd0, out_valid}, 32'd0);
      chk("t6_rst_irdy", {28'd0, in_ready}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_gid", {30'd0, grant_id}, 32'd0);
      tick();
      rst_n     = 1'b1;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      push(2'd0);
      tick();
      chk("t6_after_gid", {30'd0, grant_id}, 32'd0);
      tick();
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      tick();
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rr_mux4_arbiter
